// File: rtl/reversi_accel_eval_pkg.sv
// Shared widths, tag/state types and the signed clamp helper for the
// board-evaluation accumulator.
package reversi_accel_eval_pkg;

   localparam int unsigned EVAL_MUL_LAT    = 3;
   localparam int unsigned EVAL_PROD_W     = 28;
   localparam int unsigned EVAL_ACC_W      = 32;
   localparam int unsigned EVAL_OUT_W      = 16;
   localparam int unsigned EVAL_FRAC_SHIFT = 4;
   localparam int unsigned SAT_W           = 64;

   typedef struct packed {
      logic valid;
      logic first;
      logic last;
   } eval_tag_t;

   typedef enum logic {
      ACC  = 1'b0,
      HOLD = 1'b1
   } eval_state_t;

   typedef struct packed {
      logic                    sat;
      logic signed [SAT_W-1:0] val;
   } sat_res_t;

   // Clamp a wide signed value into a w-bit signed range; sat flags a clamp.
   function automatic sat_res_t sat_signed(input logic signed [SAT_W-1:0] x,
                                           input int unsigned w);
      logic signed [SAT_W-1:0] one;
      logic signed [SAT_W-1:0] max_v;
      logic signed [SAT_W-1:0] min_v;
      sat_res_t                r;
      one   = SAT_W'(1);
      max_v = (one <<< (w - 1)) - one;
      min_v = -max_v - one;
      r.sat = 1'b0;
      r.val = x;
      if (x > max_v) begin
         r.sat = 1'b1;
         r.val = max_v;
      end else if (x < min_v) begin
         r.sat = 1'b1;
         r.val = min_v;
      end
      return r;
   endfunction

endpackage

// File: rtl/reversi_accel_eval_tagdly.sv
// Enable-gated delay line keeping per-term tags aligned with the
// multiplier pipeline.
module reversi_accel_eval_tagdly
   import reversi_accel_eval_pkg::*;
#(
   parameter int unsigned DEPTH = EVAL_MUL_LAT
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      ce,
   input  eval_tag_t din,
   output eval_tag_t dout
);

   eval_tag_t line [DEPTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) line[i] <= '0;
      end else if (ce) begin
         line[0] <= din;
         for (int i = 1; i < int'(DEPTH); i++) line[i] <= line[i-1];
      end
   end

   assign dout = line[DEPTH-1];

endmodule

// File: rtl/reversi_accel_eval_accum.sv
// Saturating per-position accumulator behind the eval multiplier; emits a
// scaled score over valid/ready and stalls the multiply pipe on backpressure.
module reversi_accel_eval_accum
   import reversi_accel_eval_pkg::*;
#(
   parameter int unsigned MUL_LAT    = EVAL_MUL_LAT,
   parameter int unsigned PROD_W     = EVAL_PROD_W,
   parameter int unsigned ACC_W      = EVAL_ACC_W,
   parameter int unsigned FRAC_SHIFT = EVAL_FRAC_SHIFT,
   parameter int unsigned OUT_W      = EVAL_OUT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic              in_first,
   input  logic              in_last,
   output logic              mul_ce,
   input  logic [PROD_W-1:0] mul_dout,
   output logic [OUT_W-1:0]  score,
   output logic              score_sat,
   output logic              score_valid,
   input  logic              score_ready
);

   eval_tag_t               tag_in;
   eval_tag_t               tag_out;
   eval_state_t             state;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] base;
   logic signed [ACC_W-1:0] acc_nxt;
   logic signed [ACC_W-1:0] shifted;
   logic signed [ACC_W:0]   p_ext;
   logic signed [ACC_W:0]   sum;
   sat_res_t                acc_clamp;
   sat_res_t                out_clamp;
   logic [OUT_W-1:0]        score_nxt;
   logic                    sat_flag;
   logic                    last_done;
   logic                    restart;
   logic                    flag_nxt;
   logic                    score_sat_nxt;
   logic                    acc_en;
   logic                    take_last;

   assign mul_ce    = ~score_valid | score_ready;
   assign tag_in    = '{valid: in_valid, first: in_valid & in_first, last: in_valid & in_last};
   assign acc_en    = mul_ce & tag_out.valid;
   assign take_last = acc_en & tag_out.last;

   reversi_accel_eval_tagdly #(.DEPTH(MUL_LAT)) u_tagdly (
      .clk   (clk),
      .reset (reset),
      .ce    (mul_ce),
      .din   (tag_in),
      .dout  (tag_out)
   );

   // A new position starts from zero on an explicit first or after a completed one.
   always_comb begin
      restart       = tag_out.first | last_done;
      base          = restart ? '0 : acc;
      p_ext         = (ACC_W+1)'($signed(mul_dout));
      sum           = {base[ACC_W-1], base} + p_ext;
      acc_clamp     = sat_signed(SAT_W'(sum), ACC_W);
      acc_nxt       = ACC_W'(acc_clamp.val);
      shifted       = acc_nxt >>> FRAC_SHIFT;
      out_clamp     = sat_signed(SAT_W'(shifted), OUT_W);
      score_nxt     = OUT_W'(out_clamp.val);
      flag_nxt      = (restart ? 1'b0 : sat_flag) | acc_clamp.sat;
      score_sat_nxt = flag_nxt | out_clamp.sat;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ACC;
         acc         <= '0;
         sat_flag    <= 1'b0;
         last_done   <= 1'b0;
         score       <= '0;
         score_sat   <= 1'b0;
         score_valid <= 1'b0;
      end else begin
         if (acc_en) begin
            acc       <= acc_nxt;
            sat_flag  <= flag_nxt;
            last_done <= tag_out.last;
         end
         case (state)
            ACC: begin
               if (take_last) begin
                  state       <= HOLD;
                  score_valid <= 1'b1;
                  score       <= score_nxt;
                  score_sat   <= score_sat_nxt;
               end
            end
            HOLD: begin
               // Handshake completes this edge; a coincident last reloads in place.
               if (score_ready) begin
                  if (take_last) begin
                     score     <= score_nxt;
                     score_sat <= score_sat_nxt;
                  end else begin
                     state       <= ACC;
                     score_valid <= 1'b0;
                  end
               end
            end
            default: state <= ACC;
         endcase
      end
   end

endmodule

// File: tb/tb_reversi_accel_eval_accum.sv
// Directed and randomised checks of the eval accumulator against a
// behavioural 3-stage multiplier and hand-computed scores.
module tb_reversi_accel_eval_accum;

   logic               clk = 1'b0;
   logic               reset;
   logic               in_valid;
   logic               in_first;
   logic               in_last;
   logic               mul_ce;
   logic [27:0]        mul_dout;
   logic [15:0]        score;
   logic               score_sat;
   logic               score_valid;
   logic               score_ready;
   logic signed [15:0] din0;
   logic signed [11:0] din1;
   logic signed [27:0] p1, p2, p3;

   int n_vec = 0;
   int n_fail = 0;
   int exp_score[$];
   bit exp_sat[$];
   int ready_mode = 0;
   int stall_cnt = 0;

   always #5 clk = ~clk;

   reversi_accel_eval_accum dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_first    (in_first),
      .in_last     (in_last),
      .mul_ce      (mul_ce),
      .mul_dout    (mul_dout),
      .score       (score),
      .score_sat   (score_sat),
      .score_valid (score_valid),
      .score_ready (score_ready)
   );

   // Behavioural 16s x 12s multiplier, three ce-qualified stages.
   always_ff @(posedge clk) begin
      if (reset) begin
         p1 <= '0;
         p2 <= '0;
         p3 <= '0;
      end else if (mul_ce) begin
         p1 <= 28'(din0) * 28'(din1);
         p2 <= p1;
         p3 <= p2;
      end
   end
   assign mul_dout = p3;

   task automatic chk(input string tag, input int obs, input int expv);
      n_vec++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
      end
   endtask

   task automatic push_exp(input int s, input bit sat);
      exp_score.push_back(s);
      exp_sat.push_back(sat);
   endtask

   task automatic issue(input int a, input int b, input bit f, input bit l);
      bit ce_now;
      bit ok;
      ok = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      din0     = 16'(a);
      din1     = 12'(b);
      in_first = f;
      in_last  = l;
      for (int i = 0; i < 200; i++) begin
         #2;
         ce_now = mul_ce;
         @(posedge clk);
         if (ce_now) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("issue_accepted", int'(ok), 1);
      #1;
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 1000 && exp_score.size() != 0; i++) @(posedge clk);
      repeat (2) @(posedge clk);
      chk({tag, "_drain"}, exp_score.size(), 0);
   endtask

   // Output consumer: drives score_ready, checks stall behaviour and scores in order.
   initial begin
      int held;
      bit held_v;
      held        = 0;
      held_v      = 1'b0;
      score_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (reset) begin
            score_ready = 1'b1;
            held_v      = 1'b0;
            continue;
         end
         case (ready_mode)
            1: begin
               if (score_valid && stall_cnt > 0) begin
                  score_ready = 1'b0;
                  stall_cnt--;
               end else begin
                  score_ready = 1'b1;
               end
            end
            2:       score_ready = ($urandom_range(0, 2) != 0);
            default: score_ready = 1'b1;
         endcase
         #1;
         if (score_valid && !score_ready) begin
            chk("stall_ce", int'(mul_ce), 0);
            if (held_v) chk("stall_hold", int'($signed(score)), held);
            held   = int'($signed(score));
            held_v = 1'b1;
         end else begin
            held_v = 1'b0;
         end
         if (score_valid && score_ready) begin
            chk("score_expected", int'(exp_score.size() != 0), 1);
            if (exp_score.size() != 0) begin
               chk("score", int'($signed(score)), exp_score.pop_front());
               chk("score_sat", int'(score_sat), int'(exp_sat.pop_front()));
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
      din0     = '0;
      din1     = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("reset_valid", int'(score_valid), 0);
      chk("reset_score", int'($signed(score)), 0);
      chk("reset_sat", int'(score_sat), 0);
      chk("reset_ce", int'(mul_ce), 1);

      // 1: two-term position, 300 >>> 4 = 18
      push_exp(18, 1'b0);
      issue(100, 5, 1'b1, 1'b0);
      issue(-20, 10, 1'b0, 1'b1);
      drain("t1");

      // 2: single term -300 >>> 4 floors to -19, valid after MUL_LAT+1 cycles
      push_exp(-19, 1'b0);
      issue(-30, 10, 1'b1, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         #2;
         chk("t2_latency_valid", int'(score_valid), int'(i == 4));
      end
      drain("t2");

      // 3: accumulator clamp then a clean position clears the flag
      push_exp(32767, 1'b1);
      issue(32767, 2047, 1'b1, 1'b0);
      for (int i = 0; i < 62; i++) issue(32767, 2047, 1'b0, 1'b0);
      issue(32767, 2047, 1'b0, 1'b1);
      push_exp(1, 1'b0);
      issue(1, 16, 1'b1, 1'b1);
      drain("t3");

      // 4: stall on first score, then back-to-back positions in order
      ready_mode = 1;
      stall_cnt  = 5;
      push_exp(30, 1'b0);
      push_exp(9, 1'b0);
      push_exp(10, 1'b0);
      issue(10, 16, 1'b1, 1'b0);
      issue(20, 16, 1'b0, 1'b1);
      issue(9, 16, 1'b1, 1'b1);
      issue(3, 16, 1'b1, 1'b0);
      issue(7, 16, 1'b0, 1'b1);
      drain("t4");
      ready_mode = 0;

      // 5: reset mid-position discards the partial sum
      issue(50, 16, 1'b1, 1'b0);
      issue(60, 16, 1'b0, 1'b0);
      issue(70, 16, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("t5_reset_valid", int'(score_valid), 0);
      chk("t5_reset_score", int'($signed(score)), 0);
      chk("t5_reset_ce", int'(mul_ce), 1);
      push_exp(10, 1'b0);
      issue(8, 16, 1'b0, 1'b0);
      issue(2, 16, 1'b0, 1'b1);
      drain("t5");

      // 6: random terms, gaps and backpressure against a clamp/shift model
      ready_mode = 2;
      for (int pos = 0; pos < 10; pos++) begin
         int     nt;
         int     av[5];
         int     bv[5];
         longint acc;
         longint sc;
         bit     sat;
         bit     f;
         nt  = int'($urandom_range(1, 5));
         acc = 0;
         sat = 1'b0;
         for (int t = 0; t < nt; t++) begin
            av[t] = int'($urandom_range(0, 65535)) - 32768;
            bv[t] = int'($urandom_range(0, 4095)) - 2048;
            acc   = acc + longint'(av[t]) * longint'(bv[t]);
            if (acc > 64'sd2147483647) begin
               acc = 64'sd2147483647;
               sat = 1'b1;
            end else if (acc < -64'sd2147483648) begin
               acc = -64'sd2147483648;
               sat = 1'b1;
            end
         end
         sc = acc >>> 4;
         if (sc > 32767) begin
            sc  = 32767;
            sat = 1'b1;
         end else if (sc < -32768) begin
            sc  = -32768;
            sat = 1'b1;
         end
         push_exp(int'(sc), sat);
         for (int t = 0; t < nt; t++) begin
            f = (t == 0) && ($urandom_range(0, 3) != 0);
            issue(av[t], bv[t], f, (t == nt - 1));
            repeat ($urandom_range(0, 2)) @(posedge clk);
         end
      end
      drain("t6");
      ready_mode = 0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
